// File: rtl/phys_reg_file_if.sv
// Execute/Rename/Issue <-> physical register file bundle: writeback, allocation,
// two read ports and the wakeup broadcast. master = core side, slave = register file.
interface phys_reg_file_if #(
   parameter int NUM_PREGS = 64,
   parameter int DATA_W    = 32
);
   localparam int IDX_W = $clog2(NUM_PREGS);

   logic              ex_valid;
   logic [DATA_W-1:0] ex_dst_val;
   logic [IDX_W-1:0]  ex_dst_index;
   logic              alloc_valid;
   logic [IDX_W-1:0]  alloc_index;
   logic              rd_en_a;
   logic [IDX_W-1:0]  rd_idx_a;
   logic              rd_en_b;
   logic [IDX_W-1:0]  rd_idx_b;
   logic              rd_valid_a;
   logic [DATA_W-1:0] rd_data_a;
   logic              rd_ready_a;
   logic              rd_valid_b;
   logic [DATA_W-1:0] rd_data_b;
   logic              rd_ready_b;
   logic              wakeup_valid;
   logic [IDX_W-1:0]  wakeup_index;

   modport master (
      output ex_valid, ex_dst_val, ex_dst_index,
      output alloc_valid, alloc_index,
      output rd_en_a, rd_idx_a, rd_en_b, rd_idx_b,
      input  rd_valid_a, rd_data_a, rd_ready_a,
      input  rd_valid_b, rd_data_b, rd_ready_b,
      input  wakeup_valid, wakeup_index
   );

   modport slave (
      input  ex_valid, ex_dst_val, ex_dst_index,
      input  alloc_valid, alloc_index,
      input  rd_en_a, rd_idx_a, rd_en_b, rd_idx_b,
      output rd_valid_a, rd_data_a, rd_ready_a,
      output rd_valid_b, rd_data_b, rd_ready_b,
      output wakeup_valid, wakeup_index
   );
endinterface

// File: rtl/phys_reg_file.sv
// Physical register file with ready scoreboard, two registered read ports and wakeup.
// Optional macro PRF_WB_BYPASS_EN forwards a same-cycle writeback into the read ports.
module phys_reg_file #(
   parameter int NUM_PREGS = 64,
   parameter int DATA_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   phys_reg_file_if.slave     bus
);
   localparam int IDX_W = $clog2(NUM_PREGS);
   localparam int NPORT = 2;

   // Flop array rather than block RAM: every register must clear on reset.
   logic [DATA_W-1:0]    r_regs [NUM_PREGS];
   logic [NUM_PREGS-1:0] r_ready;

   logic                 w_wb_fire;
   logic                 w_al_fire;
   logic [NUM_PREGS-1:0] w_wr_hit;
   logic [NUM_PREGS-1:0] w_al_hit;

   logic                 w_rd_en   [NPORT];
   logic [IDX_W-1:0]     w_rd_idx  [NPORT];
   logic [DATA_W-1:0]    w_rd_data [NPORT];
   logic                 w_rd_rdy  [NPORT];

   logic                 r_rd_valid [NPORT];
   logic [DATA_W-1:0]    r_rd_data  [NPORT];
   logic                 r_rd_ready [NPORT];
   logic                 r_wake_valid;
   logic [IDX_W-1:0]     r_wake_index;

   // Index 0 is the hardwired-zero register: writes and allocs to it never fire.
   assign w_wb_fire = bus.ex_valid    && (bus.ex_dst_index != '0);
   assign w_al_fire = bus.alloc_valid && (bus.alloc_index  != '0);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PREGS; gi++) begin : g_hit
         assign w_wr_hit[gi] = w_wb_fire && (bus.ex_dst_index == IDX_W'(gi));
         assign w_al_hit[gi] = w_al_fire && (bus.alloc_index  == IDX_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PREGS; i++) begin
            r_regs[i]  <= '0;
            r_ready[i] <= 1'b1;
         end
      end else begin
         for (int i = 0; i < NUM_PREGS; i++) begin
            if (w_wr_hit[i]) r_regs[i] <= bus.ex_dst_val;
            if (w_al_hit[i])      r_ready[i] <= 1'b0;
            else if (w_wr_hit[i]) r_ready[i] <= 1'b1;
         end
      end
   end

   assign w_rd_en[0]  = bus.rd_en_a;
   assign w_rd_idx[0] = bus.rd_idx_a;
   assign w_rd_en[1]  = bus.rd_en_b;
   assign w_rd_idx[1] = bus.rd_idx_b;

   always_comb begin
      for (int p = 0; p < NPORT; p++) begin
         w_rd_data[p] = r_regs[w_rd_idx[p]];
         w_rd_rdy[p]  = r_ready[w_rd_idx[p]];
`ifdef PRF_WB_BYPASS_EN
         // A same-cycle alloc still wins the returned ready bit.
         if (w_wb_fire && (bus.ex_dst_index == w_rd_idx[p])) begin
            w_rd_data[p] = bus.ex_dst_val;
            w_rd_rdy[p]  = !(w_al_fire && (bus.alloc_index == w_rd_idx[p]));
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < NPORT; p++) begin
            r_rd_valid[p] <= 1'b0;
            r_rd_data[p]  <= '0;
            r_rd_ready[p] <= 1'b0;
         end
         r_wake_valid <= 1'b0;
         r_wake_index <= '0;
      end else begin
         for (int p = 0; p < NPORT; p++) begin
            r_rd_valid[p] <= w_rd_en[p];
            if (w_rd_en[p]) begin
               r_rd_data[p]  <= w_rd_data[p];
               r_rd_ready[p] <= w_rd_rdy[p];
            end
         end
         r_wake_valid <= w_wb_fire;
         if (w_wb_fire) r_wake_index <= bus.ex_dst_index;
      end
   end

   assign bus.rd_valid_a   = r_rd_valid[0];
   assign bus.rd_data_a    = r_rd_data[0];
   assign bus.rd_ready_a   = r_rd_ready[0];
   assign bus.rd_valid_b   = r_rd_valid[1];
   assign bus.rd_data_b    = r_rd_data[1];
   assign bus.rd_ready_b   = r_rd_ready[1];
   assign bus.wakeup_valid = r_wake_valid;
   assign bus.wakeup_index = r_wake_index;
endmodule

// File: tb/tb_phys_reg_file.sv
// Directed-vector bench for phys_reg_file; expectations follow the PRF_WB_BYPASS_EN build setting.
module tb_phys_reg_file;
   localparam int NUM_PREGS = 64;
   localparam int DATA_W    = 32;
   localparam int IDX_W     = 6;
`ifdef PRF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   phys_reg_file_if #(.NUM_PREGS(NUM_PREGS), .DATA_W(DATA_W)) bus ();

   phys_reg_file #(.NUM_PREGS(NUM_PREGS), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic              ex_v;
      logic [IDX_W-1:0]  ex_i;
      logic [DATA_W-1:0] ex_d;
      logic              al_v;
      logic [IDX_W-1:0]  al_i;
      logic              ra_en;
      logic [IDX_W-1:0]  ra_i;
      logic              rb_en;
      logic [IDX_W-1:0]  rb_i;
      logic              e_va;
      logic [DATA_W-1:0] e_da;
      logic              e_ra;
      logic              e_vb;
      logic [DATA_W-1:0] e_db;
      logic              e_rb;
      logic              e_wv;
      logic [IDX_W-1:0]  e_wi;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t vecs [16];

   function automatic vec_t mk(
      input logic ex_v, input logic [IDX_W-1:0] ex_i, input logic [DATA_W-1:0] ex_d,
      input logic al_v, input logic [IDX_W-1:0] al_i,
      input logic ra_en, input logic [IDX_W-1:0] ra_i,
      input logic rb_en, input logic [IDX_W-1:0] rb_i,
      input logic e_va, input logic [DATA_W-1:0] e_da, input logic e_ra,
      input logic e_vb, input logic [DATA_W-1:0] e_db, input logic e_rb,
      input logic e_wv, input logic [IDX_W-1:0] e_wi);
      vec_t v;
      v.ex_v = ex_v;   v.ex_i = ex_i;   v.ex_d = ex_d;
      v.al_v = al_v;   v.al_i = al_i;
      v.ra_en = ra_en; v.ra_i = ra_i;   v.rb_en = rb_en; v.rb_i = rb_i;
      v.e_va = e_va;   v.e_da = e_da;   v.e_ra = e_ra;
      v.e_vb = e_vb;   v.e_db = e_db;   v.e_rb = e_rb;
      v.e_wv = e_wv;   v.e_wi = e_wi;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.ex_valid     = v.ex_v;
      bus.ex_dst_index = v.ex_i;
      bus.ex_dst_val   = v.ex_d;
      bus.alloc_valid  = v.al_v;
      bus.alloc_index  = v.al_i;
      bus.rd_en_a      = v.ra_en;
      bus.rd_idx_a     = v.ra_i;
      bus.rd_en_b      = v.rb_en;
      bus.rd_idx_b     = v.rb_i;
   endtask

   // Wakeup index is only meaningful while wakeup_valid is expected high.
   task automatic check(input string name, input vec_t v);
      logic [2*DATA_W+4+IDX_W:0] act, exp;
      act = {bus.rd_valid_a, bus.rd_data_a, bus.rd_ready_a,
             bus.rd_valid_b, bus.rd_data_b, bus.rd_ready_b,
             bus.wakeup_valid, (v.e_wv ? bus.wakeup_index : {IDX_W{1'b0}})};
      exp = {v.e_va, v.e_da, v.e_ra, v.e_vb, v.e_db, v.e_rb, v.e_wv, v.e_wi};
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got va=%0b da=%h ra=%0b vb=%0b db=%h rb=%0b wv=%0b wi=%0d, want va=%0b da=%h ra=%0b vb=%0b db=%h rb=%0b wv=%0b wi=%0d",
                  name, bus.rd_valid_a, bus.rd_data_a, bus.rd_ready_a, bus.rd_valid_b,
                  bus.rd_data_b, bus.rd_ready_b, bus.wakeup_valid, bus.wakeup_index,
                  v.e_va, v.e_da, v.e_ra, v.e_vb, v.e_db, v.e_rb, v.e_wv, v.e_wi);
      end else begin
         $display("ok   %s: va=%0b da=%h ra=%0b vb=%0b db=%h rb=%0b wv=%0b wi=%0d",
                  name, bus.rd_valid_a, bus.rd_data_a, bus.rd_ready_a, bus.rd_valid_b,
                  bus.rd_data_b, bus.rd_ready_b, bus.wakeup_valid, bus.wakeup_index);
      end
   endtask

   task automatic step(input string name, input vec_t v);
      @(negedge clk);
      drive(v);
      @(posedge clk);
      #2;
      check(name, v);
   endtask

   initial begin
      logic [DATA_W-1:0] x12;
      logic              y12;
      vec_t              v;
      x12 = BYP ? 32'h0000_0055 : 32'hA5A5_A5A5;
      y12 = BYP ? 1'b0 : 1'b1;

      //              ex  idx data          al  idx rA  idx rB  idx | vA dA            rA vB dB                       rB              wv wi
      vecs[0]  = mk(0, 0,  32'h0,         0, 0,  1, 5,  1, 0,  1, 32'h0,         1, 1, 32'h0,                   1,              0, 0);
      vecs[1]  = mk(0, 0,  32'h0,         1, 9,  0, 0,  0, 0,  0, 32'h0,         1, 0, 32'h0,                   1,              0, 0);
      vecs[2]  = mk(0, 0,  32'h0,         0, 0,  1, 9,  0, 0,  1, 32'h0,         0, 0, 32'h0,                   1,              0, 0);
      vecs[3]  = mk(1, 9,  32'hDEADBEEF,  0, 0,  0, 0,  0, 0,  0, 32'h0,         0, 0, 32'h0,                   1,              1, 9);
      vecs[4]  = mk(0, 0,  32'h0,         0, 0,  1, 9,  1, 9,  1, 32'hDEADBEEF,  1, 1, 32'hDEADBEEF,            1,              0, 0);
      vecs[5]  = mk(1, 0,  32'h12345678,  0, 0,  0, 0,  1, 0,  0, 32'hDEADBEEF,  1, 1, 32'h0,                   1,              0, 0);
      vecs[6]  = mk(0, 0,  32'h0,         0, 0,  1, 0,  0, 0,  1, 32'h0,         1, 0, 32'h0,                   1,              0, 0);
      vecs[7]  = mk(1, 12, 32'hA5A5A5A5,  0, 0,  1, 12, 0, 0,  1, (BYP ? 32'hA5A5A5A5 : 32'h0), 1, 0, 32'h0,    1,              1, 12);
      vecs[8]  = mk(0, 0,  32'h0,         0, 0,  1, 12, 0, 0,  1, 32'hA5A5A5A5,  1, 0, 32'h0,                   1,              0, 0);
      vecs[9]  = mk(1, 20, 32'h42,        1, 20, 0, 0,  1, 20, 0, 32'hA5A5A5A5,  1, 1, (BYP ? 32'h42 : 32'h0),  (BYP ? 1'b0 : 1'b1), 1, 20);
      vecs[10] = mk(0, 0,  32'h0,         0, 0,  0, 0,  1, 20, 0, 32'hA5A5A5A5,  1, 1, 32'h42,                  0,              0, 0);
      vecs[11] = mk(0, 0,  32'h0,         1, 0,  1, 0,  0, 0,  1, 32'h0,         1, 0, 32'h42,                  0,              0, 0);
      vecs[12] = mk(1, 12, 32'h55,        1, 12, 1, 12, 1, 12, 1, x12,           y12, 1, x12,                   y12,            1, 12);
      vecs[13] = mk(0, 0,  32'h0,         0, 0,  1, 12, 0, 0,  1, 32'h55,        0, 0, x12,                     y12,            0, 0);
      vecs[14] = mk(0, 0,  32'h0,         1, 9,  0, 0,  1, 9,  0, 32'h55,        0, 1, 32'hDEADBEEF,            1,              0, 0);
      vecs[15] = mk(0, 0,  32'h0,         0, 0,  1, 9,  0, 0,  1, 32'hDEADBEEF,  0, 0, 32'hDEADBEEF,            1,              0, 0);

      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         step($sformatf("vec%0d", i), vecs[i]);
      end

      // Reset asserted mid-operation with live inputs: everything ignored and flushed.
      @(negedge clk);
      rst = 1'b1;
      drive(mk(1, 7, 32'h1, 1, 3, 1, 9, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #2;
      check("reset_midop", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0;
      v = mk(0, 0, 0, 0, 0, 1, 7, 1, 20, 1, 32'h0, 1, 1, 32'h0, 1, 0, 0);
      drive(v);
      @(posedge clk);
      #2;
      check("post_reset_rd7_rd20", v);
      step("post_reset_rd9_rd12", mk(0, 0, 0, 0, 0, 1, 9, 1, 12, 1, 32'h0, 1, 1, 32'h0, 1, 0, 0));
      step("post_reset_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/phys_reg_file.md
Name: phys_reg_file

Overview:
- Physical register file: receiving end of the Execute-to-PhysRegFile writeback interface (ex_valid, ex_dst_val, ex_dst_index).
- Holds NUM_PREGS data registers plus a per-register ready scoreboard.
- Serves two registered read ports to issue/operand-fetch.
- Rename clears ready on allocation; Execute writebacks set it. Each writeback is broadcast one cycle later as a wakeup to the scheduler.

Parameters:
- NUM_PREGS, 64, number of physical registers; power of two, >= 4.
- DATA_W, 32, register data width.
- IDX_W, $clog2(NUM_PREGS), physical register index width (derived; not overridden).

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- ex_valid  input  1  writeback strobe from Execute.
- ex_dst_val  input  DATA_W  writeback data.
- ex_dst_index  input  IDX_W  writeback destination preg.
- alloc_valid  input  1  rename allocated a new destination preg this cycle.
- alloc_index  input  IDX_W  allocated preg; its ready bit is cleared.
- rd_en_a  input  1  read request, port A.
- rd_idx_a  input  IDX_W  read index, port A.
- rd_en_b  input  1  read request, port B.
- rd_idx_b  input  IDX_W  read index, port B.
- rd_valid_a  output  1  port A response valid (1 cycle after rd_en_a).
- rd_data_a  output  DATA_W  port A data.
- rd_ready_a  output  1  port A ready bit at sample time.
- rd_valid_b  output  1  port B response valid.
- rd_data_b  output  DATA_W  port B data.
- rd_ready_b  output  1  port B ready bit.
- wakeup_valid  output  1  registered writeback broadcast.
- wakeup_index  output  IDX_W  preg just written.

Behaviour:
- Reset (rst=1 at clock edge):
  - All data registers = 0; all ready bits = 1.
  - rd_valid_a/b = 0, rd_data_a/b = 0, rd_ready_a/b = 0.
  - wakeup_valid = 0, wakeup_index = 0.
  - Reset mid-operation discards any in-flight read response and wakeup. Inputs are ignored during a reset cycle.
- Preg 0 is hardwired zero:
  - Writes and allocs to index 0 are dropped; reads return 0 with ready=1.
  - No wakeup is generated for index 0.
- Writeback:
  - ex_valid=1 and index != 0 at edge T: regs[idx] <= ex_dst_val; ready[idx] <= 1.
  - At T+1: wakeup_valid=1, wakeup_index=idx. Otherwise wakeup_valid=0.
- Allocation: alloc_valid=1 and index != 0: ready[idx] <= 0. Data is untouched.
- Same-cycle alloc and writeback to the same index: data is written, ready ends at 0 (alloc wins), and the wakeup is still emitted.
- Reads:
  - Registered, latency 1. rd_en_x at cycle T gives rd_valid_x=1 at T+1 with data/ready sampled from state before the T edge (except for bypass, see Optional Feature).
  - rd_en_x=0 gives rd_valid_x=0 next cycle; rd_data_x/rd_ready_x hold their previous values.
  - Ports A and B are fully independent and may read the same index.
- Out-of-range indices cannot occur (index width exactly covers NUM_PREGS). No backpressure on any port.

Optional Feature:
- Macro PRF_WB_BYPASS_EN.
- Defined: a read at cycle T whose index equals a same-cycle valid writeback index (not 0) returns ex_dst_val with ready=1 at T+1. An alloc to the same index that cycle forces the returned ready to 0 but data stays bypassed.
- Undefined: the read returns the pre-write value and pre-write ready bit. The register is still updated at T.

Test Plan:
- Reset, then read A idx 5, B idx 0 -> T+1: rd_valid_a=1, data 0, ready 1; rd_valid_b=1, data 0, ready 1; wakeup_valid=0.
- Alloc idx 9; next cycle read 9 -> ready 0. Then writeback 9 = 0xDEADBEEF -> wakeup_valid=1, wakeup_index=9 one cycle later; subsequent read 9 returns 0xDEADBEEF, ready 1.
- Writeback idx 0 = 0x12345678 -> no wakeup; read 0 returns 0, ready 1.
- Same cycle: writeback 12 = 0xA5A5A5A5 and read A 12 -> with PRF_WB_BYPASS_EN: data 0xA5A5A5A5, ready 1; without: prior value (0 after reset), ready as before. A read next cycle returns 0xA5A5A5A5 in both builds.
- Same cycle: alloc 20 and writeback 20 = 0x00000042 -> wakeup 20 emitted; later read 20 returns 0x42 with ready 0.
- Issue writeback 7 = 0x1 with rst asserted the same cycle, and read 7 in the cycle after rst deasserts -> reg 7 = 0, ready 1, wakeup_valid stays 0.
